// File: rtl/id_stage.sv
// RV32I instruction-decode stage: combinational decode of the fetched word plus
// register-file operands, captured into a one-entry output register with flush.
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_op_a,
  output logic [31:0] out_op_b,
  output logic [3:0]  out_alu_op,
  output logic [4:0]  out_rd,
  output logic        out_reg_we,
  output logic        out_is_branch,
  output logic        out_is_jump,
  output logic [31:0] out_target,
  output logic        out_mem_rd,
  output logic        out_mem_wr,
  output logic [31:0] out_store_data,
  output logic [31:0] out_pc,
  output logic        out_illegal
);

  typedef struct packed {
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  alu_op;
    logic [4:0]  rd;
    logic        reg_we;
    logic        is_branch;
    logic        is_jump;
    logic [31:0] target;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] store_data;
    logic [31:0] pc;
    logic        illegal;
  } dec_t;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_BEQ = 4'd8, ALU_BNE = 4'd9, ALU_BLT = 4'd10, ALU_BGE = 4'd11;

  localparam logic [6:0] OPC_OP     = 7'b0110011, OPC_OPIMM = 7'b0010011,
                         OPC_LUI    = 7'b0110111, OPC_AUIPC = 7'b0010111,
                         OPC_JAL    = 7'b1101111, OPC_JALR  = 7'b1100111,
                         OPC_BRANCH = 7'b1100011, OPC_LOAD  = 7'b0000011,
                         OPC_STORE  = 7'b0100011;

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic [4:0]  rd_s;
  logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
  logic        ill_s, wr_s;
  dec_t        dec_s;
  dec_t        out_d, out_q;
  logic        valid_d, valid_q;

  assign opcode_s  = in_inst[6:0];
  assign funct3_s  = in_inst[14:12];
  assign funct7_s  = in_inst[31:25];
  assign rd_s      = in_inst[11:7];
  assign rf_raddr1 = in_inst[19:15];
  assign rf_raddr2 = in_inst[24:20];

  assign imm_i_s = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b_s = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u_s = {in_inst[31:12], 12'd0};
  assign imm_j_s = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  // Instruction decode; any unsupported encoding collapses to a bare illegal entry.
  always_comb begin
    dec_s    = '0;
    dec_s.pc = in_pc;
    ill_s    = 1'b0;
    wr_s     = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        dec_s.op_a = rf_rdata1;
        dec_s.op_b = rf_rdata2;
        wr_s       = 1'b1;
        case (funct3_s)
          3'b000: begin
            if (funct7_s == 7'h00)      dec_s.alu_op = ALU_ADD;
            else if (funct7_s == 7'h20) dec_s.alu_op = ALU_SUB;
            else                        ill_s = 1'b1;
          end
          3'b111:  begin dec_s.alu_op = ALU_AND; ill_s = (funct7_s != 7'h00); end
          3'b110:  begin dec_s.alu_op = ALU_OR;  ill_s = (funct7_s != 7'h00); end
          3'b100:  begin dec_s.alu_op = ALU_XOR; ill_s = (funct7_s != 7'h00); end
          3'b001: begin
            dec_s.alu_op = ALU_SLL;
            dec_s.op_b   = {27'd0, rf_rdata2[4:0]};
            ill_s        = (funct7_s != 7'h00);
          end
          3'b101: begin
            dec_s.op_b = {27'd0, rf_rdata2[4:0]};
            if (funct7_s == 7'h00)      dec_s.alu_op = ALU_SRL;
            else if (funct7_s == 7'h20) dec_s.alu_op = ALU_SRA;
            else                        ill_s = 1'b1;
          end
          default: ill_s = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        dec_s.op_a = rf_rdata1;
        dec_s.op_b = imm_i_s;
        wr_s       = 1'b1;
        case (funct3_s)
          3'b000:  dec_s.alu_op = ALU_ADD;
          3'b111:  dec_s.alu_op = ALU_AND;
          3'b110:  dec_s.alu_op = ALU_OR;
          3'b100:  dec_s.alu_op = ALU_XOR;
          3'b001: begin
            dec_s.alu_op = ALU_SLL;
            dec_s.op_b   = {27'd0, in_inst[24:20]};
            ill_s        = (funct7_s != 7'h00);
          end
          3'b101: begin
            dec_s.op_b = {27'd0, in_inst[24:20]};
            if (funct7_s == 7'h00)      dec_s.alu_op = ALU_SRL;
            else if (funct7_s == 7'h20) dec_s.alu_op = ALU_SRA;
            else                        ill_s = 1'b1;
          end
          default: ill_s = 1'b1;
        endcase
      end
      OPC_LUI:   begin dec_s.op_b = imm_u_s; wr_s = 1'b1; end
      OPC_AUIPC: begin dec_s.op_a = in_pc; dec_s.op_b = imm_u_s; wr_s = 1'b1; end
      OPC_JAL: begin
        dec_s.op_a    = in_pc;
        dec_s.op_b    = 32'd4;
        dec_s.target  = in_pc + imm_j_s;
        dec_s.is_jump = 1'b1;
        wr_s          = 1'b1;
      end
      OPC_JALR: begin
        dec_s.op_a    = in_pc;
        dec_s.op_b    = 32'd4;
        dec_s.target  = (rf_rdata1 + imm_i_s) & ~32'd1;
        dec_s.is_jump = 1'b1;
        wr_s          = 1'b1;
        ill_s         = (funct3_s != 3'b000);
      end
      OPC_BRANCH: begin
        dec_s.op_a      = rf_rdata1;
        dec_s.op_b      = rf_rdata2;
        dec_s.target    = in_pc + imm_b_s;
        dec_s.is_branch = 1'b1;
        case (funct3_s)
          3'b000:  dec_s.alu_op = ALU_BEQ;
          3'b001:  dec_s.alu_op = ALU_BNE;
          3'b100:  dec_s.alu_op = ALU_BLT;
          3'b101:  dec_s.alu_op = ALU_BGE;
          default: ill_s = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec_s.op_a   = rf_rdata1;
        dec_s.op_b   = imm_i_s;
        dec_s.mem_rd = 1'b1;
        wr_s         = 1'b1;
        ill_s        = (funct3_s != 3'b010);
      end
      OPC_STORE: begin
        dec_s.op_a       = rf_rdata1;
        dec_s.op_b       = imm_s_s;
        dec_s.mem_wr     = 1'b1;
        dec_s.store_data = rf_rdata2;
        ill_s            = (funct3_s != 3'b010);
      end
      default: ill_s = 1'b1;
    endcase
    if (ill_s) begin
      dec_s         = '0;
      dec_s.pc      = in_pc;
      dec_s.illegal = 1'b1;
    end else begin
      dec_s.rd     = wr_s ? rd_s : 5'd0;
      dec_s.reg_we = wr_s & (rd_s != 5'd0);
    end
  end

  assign in_ready = flush | ~valid_q | out_ready;

  // Output register control: flush, then capture, then drain.
  always_comb begin
    valid_d = valid_q;
    out_d   = out_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      valid_d = 1'b1;
      out_d   = dec_s;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_op_a       = out_q.op_a;
  assign out_op_b       = out_q.op_b;
  assign out_alu_op     = out_q.alu_op;
  assign out_rd         = out_q.rd;
  assign out_reg_we     = out_q.reg_we;
  assign out_is_branch  = out_q.is_branch;
  assign out_is_jump    = out_q.is_jump;
  assign out_target     = out_q.target;
  assign out_mem_rd     = out_q.mem_rd;
  assign out_mem_wr     = out_q.mem_wr;
  assign out_store_data = out_q.store_data;
  assign out_pc         = out_q.pc;
  assign out_illegal    = out_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: instructions are built from their meaning
// (kind, registers, immediate value) and expected outputs follow from that meaning.
module tb_id_stage;

  typedef struct packed {
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  alu_op;
    logic [4:0]  rd;
    logic        reg_we;
    logic        is_branch;
    logic        is_jump;
    logic [31:0] target;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] store_data;
    logic [31:0] pc;
    logic        illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_inst = 32'd0, in_pc = 32'd0;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        flush = 1'b0;
  logic        out_valid, out_ready = 1'b1;
  logic [31:0] out_op_a, out_op_b, out_target, out_store_data, out_pc;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rd;
  logic        out_reg_we, out_is_branch, out_is_jump, out_mem_rd, out_mem_wr, out_illegal;
  logic [31:0] rf [32];
  exp_t        obs_s;
  int          tests = 0, fails = 0;

  always #5 clk = ~clk;

  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];
  assign obs_s = {out_op_a, out_op_b, out_alu_op, out_rd, out_reg_we, out_is_branch, out_is_jump,
                  out_target, out_mem_rd, out_mem_wr, out_store_data, out_pc, out_illegal};

  id_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_op_a(out_op_a), .out_op_b(out_op_b),
    .out_alu_op(out_alu_op), .out_rd(out_rd), .out_reg_we(out_reg_we), .out_is_branch(out_is_branch),
    .out_is_jump(out_is_jump), .out_target(out_target), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
    .out_store_data(out_store_data), .out_pc(out_pc), .out_illegal(out_illegal)
  );

  // kind: 0 R-ALU, 1 I-ALU, 2 shift-imm, 3 LUI, 4 AUIPC, 5 JAL, 6 JALR, 7 branch, 8 LW, 9 SW, 10 illegal
  task automatic gen(input int kind, input int sub, input int rd, input int rs1, input int rs2,
                     input int imm, input logic [31:0] pc, output logic [31:0] inst, output exp_t e);
    logic [31:0] a, b, im, u;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  rdv, r1, r2;
    a = rf[rs1]; b = rf[rs2]; im = imm;
    rdv = 5'(rd); r1 = 5'(rs1); r2 = 5'(rs2);
    e = '0; e.pc = pc; inst = 32'd0; f7 = 7'd0; f3 = 3'd0;
    case (kind)
      0: begin
        case (sub)
          0: {f7, f3} = {7'h00, 3'b000};
          1: {f7, f3} = {7'h20, 3'b000};
          2: {f7, f3} = {7'h00, 3'b111};
          3: {f7, f3} = {7'h00, 3'b110};
          4: {f7, f3} = {7'h00, 3'b100};
          5: {f7, f3} = {7'h00, 3'b001};
          6: {f7, f3} = {7'h00, 3'b101};
          default: {f7, f3} = {7'h20, 3'b101};
        endcase
        inst = {f7, r2, r1, f3, rdv, 7'b0110011};
        e.op_a = a; e.op_b = (sub >= 5) ? (b % 32'd32) : b;
        e.alu_op = 4'(sub); e.rd = rdv; e.reg_we = (rd != 0);
      end
      1: begin
        case (sub)
          0: begin f3 = 3'b000; e.alu_op = 4'd0; end
          1: begin f3 = 3'b111; e.alu_op = 4'd2; end
          2: begin f3 = 3'b110; e.alu_op = 4'd3; end
          default: begin f3 = 3'b100; e.alu_op = 4'd4; end
        endcase
        inst = {im[11:0], r1, f3, rdv, 7'b0010011};
        e.op_a = a; e.op_b = im; e.rd = rdv; e.reg_we = (rd != 0);
      end
      2: begin
        case (sub)
          0: begin f7 = 7'h00; f3 = 3'b001; e.alu_op = 4'd5; end
          1: begin f7 = 7'h00; f3 = 3'b101; e.alu_op = 4'd6; end
          default: begin f7 = 7'h20; f3 = 3'b101; e.alu_op = 4'd7; end
        endcase
        u = im % 32'd32;
        inst = {f7, u[4:0], r1, f3, rdv, 7'b0010011};
        e.op_a = a; e.op_b = u; e.rd = rdv; e.reg_we = (rd != 0);
      end
      3, 4: begin
        u = im % 32'h100000;
        inst = {u[19:0], rdv, (kind == 3) ? 7'b0110111 : 7'b0010111};
        e.op_a = (kind == 3) ? 32'd0 : pc; e.op_b = u * 32'h1000;
        e.rd = rdv; e.reg_we = (rd != 0);
      end
      5: begin
        inst = {im[20], im[10:1], im[11], im[19:12], rdv, 7'b1101111};
        e.op_a = pc; e.op_b = 32'd4; e.target = pc + im; e.is_jump = 1'b1;
        e.rd = rdv; e.reg_we = (rd != 0);
      end
      6: begin
        inst = {im[11:0], r1, 3'b000, rdv, 7'b1100111};
        u = a + im;
        e.op_a = pc; e.op_b = 32'd4; e.target = u - (u % 32'd2); e.is_jump = 1'b1;
        e.rd = rdv; e.reg_we = (rd != 0);
      end
      7: begin
        case (sub)
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
        inst = {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], 7'b1100011};
        e.op_a = a; e.op_b = b; e.alu_op = 4'(8 + sub); e.target = pc + im; e.is_branch = 1'b1;
      end
      8: begin
        inst = {im[11:0], r1, 3'b010, rdv, 7'b0000011};
        e.op_a = a; e.op_b = im; e.mem_rd = 1'b1; e.rd = rdv; e.reg_we = (rd != 0);
      end
      9: begin
        inst = {im[11:5], r2, r1, 3'b010, im[4:0], 7'b0100011};
        e.op_a = a; e.op_b = im; e.mem_wr = 1'b1; e.store_data = b;
      end
      default: begin
        case (sub)
          0: inst = {7'h00, r2, r1, 3'b110, 5'd0, 7'b1100011};
          1: inst = {7'h00, r2, r1, 3'b111, 5'd0, 7'b1100011};
          2: inst = {7'h00, r2, r1, 3'b010, rdv, 7'b0110011};
          3: inst = 32'hFFFF_FFFF;
          4: inst = {7'h01, r2, r1, 3'b000, rdv, 7'b0110011};
          5: inst = {7'h20, 5'd3, r1, 3'b001, rdv, 7'b0010011};
          6: inst = {12'd0, r1, 3'b000, rdv, 7'b0000011};
          7: inst = {12'd0, r1, 3'b000, rdv, 7'b0001111};
          default: inst = {12'd0, r1, 3'b001, rdv, 7'b1100111};
        endcase
        e.illegal = 1'b1;
      end
    endcase
  endtask

  task automatic send_one(input logic [31:0] inst, input logic [31:0] pc, input logic rdy);
    @(negedge clk);
    in_valid = 1'b1; in_inst = inst; in_pc = pc; out_ready = rdy; flush = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] inst; exp_t e;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    tests++; if (obs_s !== '0) begin fails++; $display("FAIL reset_fields: got %h want 0", obs_s); end
    gen(0, 0, 7, 3, 4, 0, 32'h40, inst, e);
    send_one(inst, 32'h40, 1'b0);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL pre_reset_valid: got %b want 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL async_reset_valid: got %b want 0", out_valid); end
    tests++; if (obs_s !== '0) begin fails++; $display("FAIL async_reset_fields: got %h want 0", obs_s); end
    @(negedge clk) rst = 1'b0;
    gen(1, 0, 1, 0, 0, 5, 32'h80, inst, e);
    send_one(inst, 32'h80, 1'b1);
    tests++; if (obs_s !== e) begin fails++; $display("FAIL addi: got %h want %h", obs_s, e); end
    tests++; if (out_op_b !== 32'd5 || out_reg_we !== 1'b1 || out_rd !== 5'd1)
      begin fails++; $display("FAIL addi_fields: got op_b=%h we=%b rd=%0d want 5/1/1", out_op_b, out_reg_we, out_rd); end
  endtask

  task automatic test_alu();
    logic [31:0] inst; exp_t e;
    rf[1] = 32'd7; rf[2] = 32'd9; rf[5] = 32'h8000_0001; rf[6] = 32'h23;
    gen(0, 1, 3, 1, 2, 0, 32'h100, inst, e);
    send_one(inst, 32'h100, 1'b1);
    tests++; if (obs_s !== e || out_op_a !== 32'd7 || out_op_b !== 32'd9 || out_alu_op !== 4'd1)
      begin fails++; $display("FAIL sub: got %h want %h", obs_s, e); end
    gen(2, 2, 4, 5, 0, 31, 32'h104, inst, e);
    send_one(inst, 32'h104, 1'b1);
    tests++; if (obs_s !== e || out_op_b !== 32'd31 || out_alu_op !== 4'd7)
      begin fails++; $display("FAIL srai: got %h want %h", obs_s, e); end
    gen(0, 5, 8, 1, 6, 0, 32'h108, inst, e);
    send_one(inst, 32'h108, 1'b1);
    tests++; if (obs_s !== e || out_op_b !== 32'd3 || out_alu_op !== 4'd5)
      begin fails++; $display("FAIL sll: got %h want %h", obs_s, e); end
  endtask

  task automatic test_control();
    logic [31:0] inst; exp_t e;
    rf[2] = 32'h200;
    gen(7, 3, 0, 1, 2, -8, 32'h100, inst, e);
    send_one(inst, 32'h100, 1'b1);
    tests++; if (obs_s !== e || out_target !== 32'hF8 || out_alu_op !== 4'd11 || out_reg_we !== 1'b0)
      begin fails++; $display("FAIL bge: got %h want %h", obs_s, e); end
    gen(6, 0, 1, 2, 0, 3, 32'h300, inst, e);
    send_one(inst, 32'h300, 1'b1);
    tests++; if (obs_s !== e || out_target !== 32'h202 || out_op_a !== 32'h300 || out_op_b !== 32'd4)
      begin fails++; $display("FAIL jalr: got %h want %h", obs_s, e); end
    gen(5, 0, 0, 0, 0, 8, 32'hFFFF_FFFC, inst, e);
    send_one(inst, 32'hFFFF_FFFC, 1'b1);
    tests++; if (obs_s !== e || out_reg_we !== 1'b0 || out_target !== 32'd4 || out_is_jump !== 1'b1)
      begin fails++; $display("FAIL jal_x0_wrap: got %h want %h", obs_s, e); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ia, ib, ic; exp_t ea, eb, ec;
    gen(1, 1, 9, 1, 0, -3, 32'h500, ia, ea);
    gen(8, 0, 10, 2, 0, 100, 32'h504, ib, eb);
    gen(0, 4, 11, 1, 2, 0, 32'h508, ic, ec);
    send_one(ia, 32'h500, 1'b1);
    tests++; if (obs_s !== ea || out_valid !== 1'b1) begin fails++; $display("FAIL b2b_a: got %h want %h", obs_s, ea); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_inst = ib; in_pc = 32'h504; out_ready = 1'b0;
      #1;
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_ready: got %b want 0", in_ready); end
      @(posedge clk); #1;
      tests++; if (obs_s !== ea || out_valid !== 1'b1) begin fails++; $display("FAIL stall_hold: got %h want %h", obs_s, ea); end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL release_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    tests++; if (obs_s !== eb || out_valid !== 1'b1) begin fails++; $display("FAIL b2b_b: got %h want %h", obs_s, eb); end
    @(negedge clk);
    in_inst = ic; in_pc = 32'h508;
    @(posedge clk); #1;
    tests++; if (obs_s !== ec || out_valid !== 1'b1) begin fails++; $display("FAIL b2b_c: got %h want %h", obs_s, ec); end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    logic [31:0] ia, ib; exp_t ea, eb;
    gen(3, 0, 12, 0, 0, 32'h12345, 32'h600, ia, ea);
    gen(4, 0, 13, 0, 0, 32'h54321, 32'h604, ib, eb);
    send_one(ia, 32'h600, 1'b0);
    tests++; if (obs_s !== ea || out_valid !== 1'b1) begin fails++; $display("FAIL flush_pre: got %h want %h", obs_s, ea); end
    @(negedge clk);
    in_valid = 1'b1; in_inst = ib; in_pc = 32'h604; flush = 1'b1; out_ready = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_kill: got %b want 0", out_valid); end
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_nothing_after: got %b want 0", out_valid); end
  endtask

  task automatic test_illegal();
    logic [31:0] inst; exp_t e;
    for (int s = 0; s < 9; s++) begin
      gen(10, s, 14, 1, 2, 0, 32'h700 + 32'(4 * s), inst, e);
      send_one(inst, 32'h700 + 32'(4 * s), 1'b1);
      tests++; if (obs_s !== e || out_valid !== 1'b1)
        begin fails++; $display("FAIL illegal_%0d: got %h valid=%b want %h", s, obs_s, out_valid, e); end
    end
    rf[3] = 32'h1000; rf[4] = 32'hCAFE_F00D;
    gen(8, 0, 5, 3, 0, -4, 32'h800, inst, e);
    send_one(inst, 32'h800, 1'b1);
    tests++; if (obs_s !== e || out_mem_rd !== 1'b1 || out_op_a !== 32'h1000 || out_op_b !== 32'hFFFF_FFFC)
      begin fails++; $display("FAIL lw: got %h want %h", obs_s, e); end
    gen(9, 0, 0, 3, 4, 2047, 32'h804, inst, e);
    send_one(inst, 32'h804, 1'b1);
    tests++; if (obs_s !== e || out_mem_wr !== 1'b1 || out_op_b !== 32'd2047 || out_store_data !== 32'hCAFE_F00D)
      begin fails++; $display("FAIL sw: got %h want %h", obs_s, e); end
  endtask

  task automatic test_random();
    exp_t q[$]; exp_t e; logic [31:0] inst, pc; logic rdy_m; int k, s, im;
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    #2 rst = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      k = $urandom_range(0, 10);
      case (k)
        0: s = $urandom_range(0, 7);
        1, 7: s = $urandom_range(0, 3);
        2: s = $urandom_range(0, 2);
        10: s = $urandom_range(0, 8);
        default: s = 0;
      endcase
      case (k)
        2: im = $urandom_range(0, 31);
        3, 4: im = $urandom_range(0, 32'hFFFFF);
        5: im = (int'($urandom_range(0, 32'hFFFFF)) - 32'h80000) * 2;
        7: im = (int'($urandom_range(0, 4095)) - 2048) * 2;
        default: im = int'($urandom_range(0, 4095)) - 2048;
      endcase
      pc = $urandom & 32'hFFFF_FFFC;
      gen(k, s, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), im, pc, inst, e);
      in_valid = ($urandom_range(0, 3) != 0); in_inst = inst; in_pc = pc;
      out_ready = ($urandom_range(0, 2) != 0); flush = ($urandom_range(0, 15) == 0);
      #1;
      tests++; if (out_valid !== (q.size() != 0))
        begin fails++; $display("FAIL rand_valid c=%0d: got %b want %b", c, out_valid, q.size() != 0); end
      rdy_m = flush | (q.size() == 0) | out_ready;
      tests++; if (in_ready !== rdy_m) begin fails++; $display("FAIL rand_ready c=%0d: got %b want %b", c, in_ready, rdy_m); end
      if (q.size() != 0) begin
        tests++; if (obs_s !== q[0]) begin fails++; $display("FAIL rand_data c=%0d: got %h want %h", c, obs_s, q[0]); end
      end
      if (flush) q.delete();
      else begin
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (in_valid && rdy_m) q.push_back(e);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    test_reset();
    test_alu();
    test_control();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode pipeline stage between fetch and the ALU/execute stage of the single-issue RV32I core. Accepts one fetched instruction per valid/ready handshake and reads the register file combinationally. Decodes the instruction into the execute stage's operand pair and 4-bit ALU op, and holds the result in a one-entry output register with valid/ready back-pressure and flush.

## Interface
- No parameters. XLEN is fixed at 32.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid / in_ready  in/out  1  fetch handshake
- in_inst  in  32  instruction word
- in_pc  in  32  instruction address
- rf_raddr1 / rf_raddr2  out  5  = in_inst[19:15] / in_inst[24:20], combinational
- rf_rdata1 / rf_rdata2  in  32  register-file data, same cycle
- flush  in  1  kill held and incoming instruction
- out_valid / out_ready  out/in  1  execute handshake
- out_op_a, out_op_b  out  32  ALU operands
- out_alu_op  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 BEQ, 9 BNE, 10 BLT, 11 BGE
- out_rd  out  5  destination register; out_reg_we  out  1
- out_is_branch, out_is_jump  out  1  instruction class
- out_target  out  32  branch/jump target
- out_mem_rd, out_mem_wr  out  1  LW / SW
- out_store_data  out  32  rs2 value for SW
- out_pc  out  32  instruction address
- out_illegal  out  1  unsupported encoding

## Operation
- Decoding is combinational from in_inst, in_pc and rf_rdata*. It is captured into the output register on an input handshake.
- R-type (0110011), funct7/funct3: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA. Operands are rs1 and rs2. For shifts, op_b = {27'b0, rs2[4:0]}.
- I-type ALU (0010011): ADDI, ANDI, ORI, XORI, SLLI, SRLI, SRAI. Operands are rs1 and the sign-extended immI. Shift-immediate uses op_b = {27'b0, shamt}. funct7 must be 0, or 0100000 for SRAI.
- LUI: op_a = 0, op_b = {imm[31:12], 12'b0}, ADD.
- AUIPC: op_a = pc, op_b = the U-immediate, ADD.
- JAL: op_a = pc, op_b = 4, ADD (link value). target = pc + immJ. is_jump = 1.
- JALR (funct3 000): op_a = pc, op_b = 4, ADD. target = (rs1 + immI) & ~1. is_jump = 1.
- BRANCH: op_a = rs1, op_b = rs2. funct3 000→BEQ, 001→BNE, 100→BLT, 101→BGE. target = pc + immB. reg_we = 0. BLTU/BGEU are illegal.
- LW (0000011, funct3 010): op_a = rs1, op_b = immI, ADD, mem_rd = 1.
- SW (0100011, funct3 010): op_a = rs1, op_b = immS, ADD, mem_wr = 1, reg_we = 0, store_data = rs2.
- out_reg_we = 1 only for writing classes with rd ≠ 0.
- Target arithmetic is modulo 2^32 (wrap-around, no flag).
- Any other opcode, funct3 or funct7 sets illegal = 1 and forces reg_we, mem_rd, mem_wr, is_branch and is_jump to 0 and alu_op to ADD. It is still passed downstream as a valid entry.
- Unused output fields are 0.

## Timing
- Reset: out_valid = 0 and every out_* register = 0 (out_alu_op = 0 = ADD). Reset takes effect immediately, independent of clk. An instruction in flight during reset is lost.
- in_ready = flush | ~out_valid | out_ready (combinational).
- Latency is 1 cycle: an instruction accepted at edge N is presented with out_valid = 1 after edge N.
- Throughput is 1 per cycle when out_ready stays high.
- Stall: while out_valid & ~out_ready, all out_* hold stable and in_ready = 0.
- Simultaneous output drain and new input: the register is reloaded in the same edge with no bubble.
- Flush has priority over everything. At the edge where flush = 1, out_valid ← 0 and the input beat is consumed but discarded. Data fields are don't-care while out_valid = 0.
- rf_rdata* is sampled only at the capture edge. Write-back forwarding is the register file's responsibility.

## Test plan
- Reset: assert rst mid-stream with out_valid = 1 → out_valid = 0 and all outputs 0 before the next clk edge. Release, then feed ADDI x1,x0,5 → one cycle later op_a = 0, op_b = 5, alu_op = 0, rd = 1, reg_we = 1.
- ALU mapping: SUB x3,x1,x2 with rdata 7/9 → op_a = 7, op_b = 9, alu_op = 1. SRAI x4,x5,31 → op_b = 31, alu_op = 7. SLL with rs2 = 0x23 → op_b = 3, alu_op = 5.
- Control flow: BGE at pc 0x100 with immB = −8 → alu_op = 11, target = 0xF8, reg_we = 0. JALR x1, 3(x2) with x2 = 0x200 → target = 0x202, op_a = pc, op_b = 4. JAL x0 → reg_we = 0.
- Back-pressure: hold out_ready = 0 for 3 cycles with in_valid = 1 → in_ready = 0 and outputs stable. Release → the next instruction is accepted the same cycle the held one drains, and the output sequence shows no loss or duplication.
- Flush: flush = 1 while out_valid = 1 and in_valid = 1 → next cycle out_valid = 0 and neither instruction appears downstream.
- Illegal: BLTU, SLT and 0xFFFFFFFF → out_valid = 1, illegal = 1, reg_we = mem_rd = mem_wr = is_branch = is_jump = 0. LW/SW → mem_rd / mem_wr = 1 with address operands rs1 and the correct immI/immS.
